// File: rtl/loader_pkg.sv
// Shared types and sizes for the reference block loader.
package loader_pkg;

  typedef enum logic [1:0] {StFill, StLaunch, StRun, StDone} state_e;

  localparam int unsigned BLK_PIX = 225;
  localparam int unsigned BUF_W   = 1800;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RUN_W   = 8;

endpackage

// File: rtl/ref_block_loader_if.sv
// Pixel stream, packed block and result handshake between the loader and its neighbours.
interface ref_block_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned BUF_W = loader_pkg::BUF_W
);
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic [BUF_W-1:0] in_buffer;
  logic             sub_rst;
  logic             res_valid;
  logic             res_ack;
  logic             err;

  modport master (
    output pix_valid, pix_data, pix_last, res_ack,
    input  pix_ready, in_buffer, sub_rst, res_valid, err
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, res_ack,
    output pix_ready, in_buffer, sub_rst, res_valid, err
  );
endinterface

// File: rtl/loader_ctrl.sv
// Loader FSM with beat and run counters; drives the slot write strobe and index.
// Framing checks on pix_last are built only with LOADER_FRAME_CHECK_EN defined.
module loader_ctrl
  import loader_pkg::*;
#(
  parameter int unsigned BlkPix    = BLK_PIX,
  parameter int unsigned RunCycles = 52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_last,
  input  logic             res_ack,
  output logic             pix_ready,
  output logic             sub_rst,
  output logic             res_valid,
  output logic             err,
  output logic             wr_en,
  output logic [CNT_W-1:0] wr_idx
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BlkPix - 1);
  localparam logic [RUN_W-1:0] RunLast = RUN_W'(RunCycles - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             ready_q, sub_rst_q, res_valid_q;
  logic             accept, is_last, early_last, miss_last;

  assign accept  = pix_valid && ready_q;
  assign is_last = (cnt_q == LastIdx);

`ifdef LOADER_FRAME_CHECK_EN
  assign early_last = pix_last && !is_last;
  assign miss_last  = !pix_last && is_last;
`else
  logic unused_pix_last;
  assign unused_pix_last = pix_last;
  assign early_last      = 1'b0;
  assign miss_last       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (early_last) begin
            // Premature end of block: drop what was collected and restart the count.
            cnt_d = '0;
          end else begin
            wr_en = 1'b1;
            if (is_last) begin
              cnt_d   = '0;
              state_d = StLaunch;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      StLaunch: begin
        run_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (run_q == RunLast) state_d = StDone;
        else                  run_d   = run_q + 1'b1;
      end
      StDone: begin
        if (res_ack) begin
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      run_q       <= '0;
      ready_q     <= 1'b0;
      sub_rst_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      ready_q     <= (state_d == StFill);
      sub_rst_q   <= (state_d == StRun) || (state_d == StDone);
      res_valid_q <= (state_d == StDone);
    end
  end

`ifdef LOADER_FRAME_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((state_q == StFill) && accept && (early_last || miss_last)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign pix_ready = ready_q;
  assign sub_rst   = sub_rst_q;
  assign res_valid = res_valid_q;
  assign wr_idx    = cnt_q;

endmodule

// File: rtl/ref_block_loader.sv
// Packs a raster block of pixels into the interpolator's flat input bus and sequences its run.
// Optional framing checks: define LOADER_FRAME_CHECK_EN.
module ref_block_loader
  import loader_pkg::*;
#(
  parameter int unsigned BLK_W      = 15,
  parameter int unsigned BLK_H      = 15,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned RUN_CYCLES = 52
) (
  input  logic               clk,
  input  logic               rst,
  ref_block_loader_if.slave  bus
);

  localparam int unsigned NPix = BLK_W * BLK_H;

  logic [PIX_W-1:0] buf_q [NPix];
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;

  loader_ctrl #(
    .BlkPix    (NPix),
    .RunCycles (RUN_CYCLES)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (bus.pix_valid),
    .pix_last  (bus.pix_last),
    .res_ack   (bus.res_ack),
    .pix_ready (bus.pix_ready),
    .sub_rst   (bus.sub_rst),
    .res_valid (bus.res_valid),
    .err       (bus.err),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NPix; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_idx] <= bus.pix_data;
    end
  end

  // Slot k sits at bit offset PIX_W*k, i.e. row-major with row pitch BLK_W pixels.
  for (genvar k = 0; k < NPix; k++) begin : g_pack
    assign bus.in_buffer[PIX_W*k +: PIX_W] = buf_q[k];
  end

endmodule

// File: tb/tb_ref_block_loader.sv
// Directed self-checking bench for ref_block_loader (default parameters).
module tb_ref_block_loader;
  import loader_pkg::*;

  localparam int RUN = 52;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ref_block_loader_if bus ();

  ref_block_loader #(.RUN_CYCLES(RUN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [BUF_W-1:0] exp_buf = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    bus.res_ack = 1'b1;
    step();
    bus.res_ack = 1'b0;
  endtask

  // Streams beats first..last_k with data k^mask; pix_last on beat last_at.
  task automatic send_beats(input int first, input int last_k, input int last_at,
                            input logic [7:0] mask, input bit gaps, input bit chk_cnt);
    for (int k = first; k <= last_k; k++) begin
      bit acc;
      int n;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'(k) ^ mask;
      bus.pix_last  = (k == last_at);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
        acc = bus.pix_ready;
        step();
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL beat_accept k=%0d: not accepted in 50 cycles, required accepted", k);
      end
      exp_buf[8*k +: 8] = 8'(k) ^ mask;
      if (chk_cnt && k < 224) begin
        checks++;
        if (dut.u_ctrl.cnt_q !== 8'(k + 1)) begin
          errors++;
          $display("FAIL cnt_track k=%0d: got %0d, required %0d", k, dut.u_ctrl.cnt_q, k + 1);
        end
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!bus.res_valid && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.sub_rst !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b sub_rst=%b res_valid=%b err=%b, required all 0",
               bus.pix_ready, bus.sub_rst, bus.res_valid, bus.err);
    end
    checks++;
    if (bus.in_buffer !== '0) begin
      errors++;
      $display("FAIL reset_buffer: in_buffer[7:0]=%h, required all zero", bus.in_buffer[7:0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++;
    if (bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.pix_ready);
    end
  endtask

  task automatic test_stream();
    int n;
    send_beats(0, 224, 224, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.sub_rst !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL launch_cycle: sub_rst=%b ready=%b, required 0 0", bus.sub_rst, bus.pix_ready);
    end
    step();
    checks++;
    if (bus.sub_rst !== 1'b1) begin
      errors++;
      $display("FAIL sub_rst_rise: got %b, required 1", bus.sub_rst);
    end
    wait_res(n);
    checks++;
    if (n != RUN) begin
      errors++;
      $display("FAIL run_latency: got %0d cycles, required %0d", n, RUN);
    end
    checks++;
    if (bus.in_buffer[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL slot_r0c0: got %h, required 00", bus.in_buffer[7:0]);
    end
    checks++;
    if (bus.in_buffer[127:120] !== 8'h0F) begin
      errors++;
      $display("FAIL slot_r1c0: got %h, required 0f", bus.in_buffer[127:120]);
    end
    checks++;
    if (bus.in_buffer[1799:1792] !== 8'hE0) begin
      errors++;
      $display("FAIL slot_last: got %h, required e0", bus.in_buffer[1799:1792]);
    end
    checks++;
    if (bus.in_buffer !== exp_buf) begin
      errors++;
      $display("FAIL stream_buffer: in_buffer differs, low byte %h required %h",
               bus.in_buffer[7:0], exp_buf[7:0]);
    end
    pulse_ack();
    checks++;
    if (bus.sub_rst !== 1'b0 || bus.res_valid !== 1'b0 || bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_ack: sub_rst=%b res_valid=%b ready=%b, required 0 0 1",
               bus.sub_rst, bus.res_valid, bus.pix_ready);
    end
  endtask

  task automatic test_gaps();
    int n;
    send_beats(0, 224, 224, 8'h5A, 1'b1, 1'b1);
    wait_res(n);
    checks++;
    if (n != RUN + 1) begin
      errors++;
      $display("FAIL gaps_latency: got %0d cycles, required %0d", n, RUN + 1);
    end
    checks++;
    if (bus.in_buffer !== exp_buf) begin
      errors++;
      $display("FAIL gaps_buffer: low byte %h required %h, top byte %h required %h",
               bus.in_buffer[7:0], exp_buf[7:0], bus.in_buffer[1799:1792], exp_buf[1799:1792]);
    end
    pulse_ack();
  endtask

  task automatic test_done_hold();
    int n;
    send_beats(0, 224, 224, 8'hC3, 1'b0, 1'b0);
    step();
    pulse_ack();
    wait_res(n);
    checks++;
    if (n != RUN - 1) begin
      errors++;
      $display("FAIL ack_in_run_ignored: res_valid after %0d cycles, required %0d", n, RUN - 1);
    end
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.pix_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.in_buffer !== exp_buf) begin
        errors++;
        $display("FAIL done_hold cycle %0d: ready=%b res_valid=%b buf_ok=%b, required 0 1 1",
                 i, bus.pix_ready, bus.res_valid, bus.in_buffer === exp_buf);
      end
    end
    bus.pix_valid = 1'b0;
    pulse_ack();
    checks++;
    if (bus.sub_rst !== 1'b0 || bus.res_valid !== 1'b0 || bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: sub_rst=%b res_valid=%b ready=%b, required 0 0 1",
               bus.sub_rst, bus.res_valid, bus.pix_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send_beats(0, 99, -1, 8'h33, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.sub_rst !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.err !== 1'b0 || bus.in_buffer !== '0 || dut.u_ctrl.cnt_q !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b sub_rst=%b res_valid=%b err=%b buf0=%b cnt=%0d, req 0",
               bus.pix_ready, bus.sub_rst, bus.res_valid, bus.err, bus.in_buffer === '0,
               dut.u_ctrl.cnt_q);
    end
    exp_buf = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    send_beats(0, 224, 224, 8'h96, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.sub_rst !== 1'b1) begin
      errors++;
      $display("FAIL fresh_launch: sub_rst=%b, required 1", bus.sub_rst);
    end
    wait_res(n);
    checks++;
    if (n != RUN || bus.in_buffer !== exp_buf) begin
      errors++;
      $display("FAIL fresh_block: latency %0d required %0d, buf_ok=%b required 1",
               n, RUN, bus.in_buffer === exp_buf);
    end
    pulse_ack();
  endtask

  task automatic test_frame();
    int n;
    send_beats(0, 50, 50, 8'h11, 1'b0, 1'b0);
`ifdef LOADER_FRAME_CHECK_EN
    checks++;
    if (bus.err !== 1'b1 || dut.u_ctrl.cnt_q !== 8'd0 || bus.pix_ready !== 1'b1 ||
        bus.sub_rst !== 1'b0) begin
      errors++;
      $display("FAIL early_last: err=%b cnt=%0d ready=%b sub_rst=%b, required 1 0 1 0",
               bus.err, dut.u_ctrl.cnt_q, bus.pix_ready, bus.sub_rst);
    end
    send_beats(0, 224, 224, 8'h22, 1'b0, 1'b0);
`else
    checks++;
    if (bus.err !== 1'b0 || dut.u_ctrl.cnt_q !== 8'd51) begin
      errors++;
      $display("FAIL last_ignored: err=%b cnt=%0d, required 0 51", bus.err, dut.u_ctrl.cnt_q);
    end
    send_beats(51, 224, 224, 8'h11, 1'b0, 1'b0);
`endif
    step();
    checks++;
    if (bus.sub_rst !== 1'b1) begin
      errors++;
      $display("FAIL frame_launch: sub_rst=%b, required 1", bus.sub_rst);
    end
    wait_res(n);
    checks++;
    if (n != RUN || bus.in_buffer !== exp_buf) begin
      errors++;
      $display("FAIL frame_block: latency %0d required %0d, buf_ok=%b required 1",
               n, RUN, bus.in_buffer === exp_buf);
    end
    checks++;
`ifdef LOADER_FRAME_CHECK_EN
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", bus.err);
    end
`else
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: got %b, required 0", bus.err);
    end
`endif
    pulse_ack();
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_last  = 1'b0;
    bus.res_ack   = 1'b0;
    test_reset();
    test_stream();
    test_gaps();
    test_done_hold();
    test_reset_mid();
    test_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
